// File: rtl/bus_xbar_pkg.sv
// Bus crossbar shared package.
// Index-width helpers and the default memory map.
package bus_xbar_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int host_idx_w(input int nr_hosts);
    return idx_w(nr_hosts);
  endfunction

  // One extra code point is reserved for the decode-miss target.
  function automatic int dev_idx_w(input int nr_devices);
    return idx_w(nr_devices + 1);
  endfunction

  localparam logic [31:0] MEM_START    = 32'h0010_0000;
  localparam logic [31:0] MEM_MASK     = 32'hFFF0_0000;
  localparam logic [31:0] GPIO_START   = 32'h8000_0000;
  localparam logic [31:0] GPIO_MASK    = 32'hFFFF_F000;
  localparam logic [31:0] UART_START   = 32'h8000_1000;
  localparam logic [31:0] UART_MASK    = 32'hFFFF_F000;
  localparam logic [31:0] PERIPH_START = 32'h8000_0000;
  localparam logic [31:0] PERIPH_MASK  = 32'hF000_0000;

endpackage

// File: rtl/bus_xbar_rr_rr_arbiter.sv
// Round-robin arbiter, one-hot grant.
// Priority starts just after the last accepted winner.
module rr_arbiter
  import bus_xbar_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Scan requesters starting at the pointer, first hit wins
  always_comb begin
    gnt_o   = '0;
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % N);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    if (w_found) gnt_o[w_sel] = 1'b1;
  end

  // Advance pointer past the winner once the grant is taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (accept_i && w_found) begin
      r_ptr <= (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
    end
  end

endmodule

// File: rtl/bus_xbar_rr.sv
// Multi-host / multi-device bus crossbar.
// Zero-latency forwarding, in-order response routing.
module bus_xbar_rr
  import bus_xbar_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 9,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2,
  parameter logic [NrDevices-1:0][AddressWidth-1:0] SLAVE_ADDR = '0,
  parameter logic [NrDevices-1:0][AddressWidth-1:0] SLAVE_MASK = '1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i
);

  localparam int HW    = host_idx_w(NrHosts);
  localparam int TW    = dev_idx_w(NrDevices);
  localparam int CW    = idx_w(MaxOutstanding + 1);
  localparam int DEPTH = NrHosts * MaxOutstanding;
  localparam int PW    = idx_w(DEPTH);
  localparam int QW    = idx_w(DEPTH + 1);

  localparam logic [TW-1:0] ERR_T = TW'(NrDevices);
  localparam logic [CW-1:0] MAX_O = CW'(MaxOutstanding);
  localparam logic [QW-1:0] FULL  = QW'(DEPTH);

  logic [NrHosts-1:0][TW-1:0] w_dec;
  logic [NrHosts-1:0]         w_elig;
  logic [NrHosts-1:0]         w_err_gnt;
  logic [NrHosts-1:0]         w_arb_req [NrDevices];
  logic [NrHosts-1:0]         w_arb_gnt [NrDevices];
  logic [NrDevices-1:0]       w_dev_req;
  logic [NrDevices-1:0]       w_pop;
  logic [NrDevices-1:0][HW-1:0] w_push_h;
  logic [NrDevices-1:0][HW-1:0] w_head;

  logic [NrHosts-1:0][CW-1:0] r_outst;
  logic [NrHosts-1:0][TW-1:0] r_tgt;
  logic [NrHosts-1:0]         r_err_pend;
  logic [HW-1:0]              r_fifo [NrDevices][DEPTH];
  logic [NrDevices-1:0][PW-1:0] r_wp;
  logic [NrDevices-1:0][PW-1:0] r_rp;
  logic [NrDevices-1:0][QW-1:0] r_cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode and per-host eligibility
  always_comb begin
    w_dec     = '0;
    w_elig    = '0;
    w_err_gnt = '0;
    for (int h = 0; h < NrHosts; h++) begin
      w_dec[h] = ERR_T;
      for (int d = NrDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h] & SLAVE_MASK[d]) == SLAVE_ADDR[d])
          w_dec[h] = TW'(d);
      end
      w_elig[h] = host_req_i[h] && !rst_i &&
                  (r_outst[h] < MAX_O) &&
                  (r_outst[h] == '0 || r_tgt[h] == w_dec[h]);
      w_err_gnt[h] = w_elig[h] && (w_dec[h] == ERR_T);
    end
  end

  // Per-device request vectors, blocked while the route FIFO is full
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      w_arb_req[d] = '0;
      for (int h = 0; h < NrHosts; h++) begin
        w_arb_req[d][h] = w_elig[h] && (w_dec[h] == TW'(d)) &&
                          (r_cnt[d] != FULL);
      end
    end
  end

  for (genvar d = 0; d < NrDevices; d++) begin : g_dev
    rr_arbiter #(.N(NrHosts)) u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (w_arb_req[d]),
      .accept_i (w_dev_req[d]),
      .gnt_o    (w_arb_gnt[d])
    );
  end

  // Forward the winning host's fields; idle devices see zeros
  always_comb begin
    host_gnt_o     = w_err_gnt;
    w_dev_req      = '0;
    w_push_h       = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      for (int h = 0; h < NrHosts; h++) begin
        if (w_arb_gnt[d][h]) begin
          host_gnt_o[h]     = 1'b1;
          w_dev_req[d]      = 1'b1;
          w_push_h[d]       = HW'(h);
          device_addr_o[d]  = host_addr_i[h];
          device_we_o[d]    = host_we_i[h];
          device_be_o[d]    = host_be_i[h];
          device_wdata_o[d] = host_wdata_i[h];
        end
      end
    end
  end

  assign device_req_o = w_dev_req;

  // Route responses back to the host at each FIFO head
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int d = 0; d < NrDevices; d++) begin
      w_pop[d]  = device_rvalid_i[d] && (r_cnt[d] != '0) && !rst_i;
      w_head[d] = r_fifo[d][r_rp[d]];
    end
    for (int h = 0; h < NrHosts; h++) begin
      if (r_err_pend[h] && !rst_i) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = 1'b1;
      end
      for (int d = 0; d < NrDevices; d++) begin
        if (w_pop[d] && w_head[d] == HW'(h)) begin
          host_rvalid_o[h] = 1'b1;
          host_rdata_o[h]  = device_rdata_i[d];
          host_err_o[h]    = device_err_i[d];
        end
      end
    end
  end

  // Per-host outstanding count, target and pending decode error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst    <= '0;
      r_tgt      <= '0;
      r_err_pend <= '0;
    end else begin
      for (int h = 0; h < NrHosts; h++) begin
        r_err_pend[h] <= w_err_gnt[h];
        if (host_gnt_o[h] && !host_rvalid_o[h])
          r_outst[h] <= r_outst[h] + 1'b1;
        else if (!host_gnt_o[h] && host_rvalid_o[h])
          r_outst[h] <= r_outst[h] - 1'b1;
        if (host_gnt_o[h] && r_outst[h] == '0)
          r_tgt[h] <= w_dec[h];
      end
    end
  end

  // Route FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      for (int d = 0; d < NrDevices; d++) begin
        if (w_dev_req[d]) r_wp[d] <= nxt(r_wp[d]);
        if (w_pop[d])     r_rp[d] <= nxt(r_rp[d]);
        if (w_dev_req[d] && !w_pop[d])
          r_cnt[d] <= r_cnt[d] + 1'b1;
        else if (!w_dev_req[d] && w_pop[d])
          r_cnt[d] <= r_cnt[d] - 1'b1;
      end
    end
  end

  // Route FIFO storage: host index of each accepted request
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < NrDevices; d++) begin
      if (w_dev_req[d]) r_fifo[d][r_wp[d]] <= w_push_h[d];
    end
  end

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Self-checking bench for bus_xbar_rr.
// Directed scenarios plus randomized traffic against a reference model.
module tb_bus_xbar_rr;
  import bus_xbar_pkg::*;

  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int BW = DW / 8;

  localparam logic [ND-1:0][AW-1:0] SADDR =
    {PERIPH_START, GPIO_START, MEM_START};
  localparam logic [ND-1:0][AW-1:0] SMASK =
    {PERIPH_MASK, GPIO_MASK, MEM_MASK};

  logic clk = 1'b0;
  logic rst_i;
  logic [NH-1:0]         host_req_i, host_gnt_o, host_we_i;
  logic [NH-1:0][AW-1:0] host_addr_i;
  logic [NH-1:0][BW-1:0] host_be_i;
  logic [NH-1:0][DW-1:0] host_wdata_i;
  logic [NH-1:0]         host_rvalid_o, host_err_o;
  logic [NH-1:0][DW-1:0] host_rdata_o;
  logic [ND-1:0]         device_req_o, device_we_o;
  logic [ND-1:0][AW-1:0] device_addr_o;
  logic [ND-1:0][BW-1:0] device_be_o;
  logic [ND-1:0][DW-1:0] device_wdata_o;
  logic [ND-1:0]         device_rvalid_i, device_err_i;
  logic [ND-1:0][DW-1:0] device_rdata_i;

  bus_xbar_rr #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
    .AddressWidth(AW), .MaxOutstanding(MO),
    .SLAVE_ADDR(SADDR), .SLAVE_MASK(SMASK)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o),
    .device_we_o(device_we_o), .device_be_o(device_be_o),
    .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_out  [NH];
  int m_tgt  [NH];
  bit m_errp [NH];
  int m_last [ND];
  int rq     [ND][$];

  // expectations for the current cycle
  logic [NH-1:0]         e_gnt, e_rv, e_er;
  logic [NH-1:0][DW-1:0] e_rd;
  logic [ND-1:0]         e_dreq, e_dwe;
  logic [ND-1:0][AW-1:0] e_daddr;
  logic [ND-1:0][BW-1:0] e_dbe;
  logic [ND-1:0][DW-1:0] e_dwd;
  int e_t [NH];
  int win [ND];
  bit pop [ND];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & SMASK[d]) == SADDR[d]) return d;
    return ND;
  endfunction

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_out[h] = 0; m_tgt[h] = 0; m_errp[h] = 0;
    end
    for (int d = 0; d < ND; d++) begin
      m_last[d] = NH - 1;
      rq[d].delete();
    end
  endtask

  task automatic model_eval();
    bit el [NH];
    e_gnt = '0; e_rv = '0; e_er = '0; e_rd = '0;
    e_dreq = '0; e_dwe = '0; e_daddr = '0; e_dbe = '0; e_dwd = '0;
    for (int d = 0; d < ND; d++) begin win[d] = -1; pop[d] = 0; end
    if (rst_i) return;
    for (int h = 0; h < NH; h++) begin
      e_t[h] = decode(host_addr_i[h]);
      el[h] = host_req_i[h] && m_out[h] < MO &&
              (m_out[h] == 0 || m_tgt[h] == e_t[h]);
      if (el[h] && e_t[h] == ND) e_gnt[h] = 1'b1;
    end
    for (int d = 0; d < ND; d++) begin
      if (rq[d].size() < NH * MO) begin
        for (int k = 1; k <= NH; k++) begin
          int h;
          h = (m_last[d] + k) % NH;
          if (win[d] < 0 && el[h] && e_t[h] == d) win[d] = h;
        end
      end
      if (win[d] >= 0) begin
        e_gnt[win[d]] = 1'b1;
        e_dreq[d]     = 1'b1;
        e_daddr[d]    = host_addr_i[win[d]];
        e_dwe[d]      = host_we_i[win[d]];
        e_dbe[d]      = host_be_i[win[d]];
        e_dwd[d]      = host_wdata_i[win[d]];
      end
      if (device_rvalid_i[d] && rq[d].size() > 0) begin
        int h;
        h = rq[d][0];
        pop[d]  = 1;
        e_rv[h] = 1'b1;
        e_rd[h] = device_rdata_i[d];
        e_er[h] = device_err_i[d];
      end
    end
    for (int h = 0; h < NH; h++) begin
      if (m_errp[h]) begin
        e_rv[h] = 1'b1; e_er[h] = 1'b1; e_rd[h] = '0;
      end
    end
  endtask

  task automatic model_update();
    if (rst_i) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      if (pop[d]) void'(rq[d].pop_front());
      if (win[d] >= 0) begin
        rq[d].push_back(win[d]);
        m_last[d] = win[d];
      end
    end
    for (int h = 0; h < NH; h++) begin
      if (e_gnt[h] && m_out[h] == 0) m_tgt[h] = e_t[h];
      m_out[h] += int'(e_gnt[h]) - int'(e_rv[h]);
      m_errp[h] = e_gnt[h] && e_t[h] == ND;
    end
  endtask

  task automatic compare_all();
    chk("gnt",    128'(host_gnt_o),     128'(e_gnt));
    chk("dreq",   128'(device_req_o),   128'(e_dreq));
    chk("daddr",  128'(device_addr_o),  128'(e_daddr));
    chk("dwe",    128'(device_we_o),    128'(e_dwe));
    chk("dbe",    128'(device_be_o),    128'(e_dbe));
    chk("dwdata", 128'(device_wdata_o), 128'(e_dwd));
    chk("rvalid", 128'(host_rvalid_o),  128'(e_rv));
    chk("rdata",  128'(host_rdata_o),   128'(e_rd));
    chk("err",    128'(host_err_o),     128'(e_er));
  endtask

  task automatic settle();
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    host_req_i = '0; host_we_i = '0; host_addr_i = '0;
    host_be_i = '0; host_wdata_i = '0;
    device_rvalid_i = '0; device_rdata_i = '0; device_err_i = '0;
  endtask

  task automatic hreq(input int h, input logic [AW-1:0] a);
    host_req_i[h]  = 1'b1;
    host_addr_i[h] = a;
    host_be_i[h]   = '1;
  endtask

  task automatic drsp(input int d, input logic [DW-1:0] rd, input logic e);
    device_rvalid_i[d] = 1'b1;
    device_rdata_i[d]  = rd;
    device_err_i[d]    = e;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    idle();
    model_reset();
    hreq(0, MEM_START);
    hreq(1, MEM_START);
    @(negedge clk);
    settle();
    chk("rst_gnt",  128'(host_gnt_o),    128'(0));
    chk("rst_dreq", 128'(device_req_o),  128'(0));
    chk("rst_rv",   128'(host_rvalid_o), 128'(0));
    adv();
    rst_i = 1'b0;

    // host1 read, answered next cycle
    idle(); hreq(1, 32'h0010_0000); settle();
    chk("r032_gnt",   128'(host_gnt_o),       128'(2'b10));
    chk("r032_dreq",  128'(device_req_o),     128'(3'b001));
    chk("r032_daddr", 128'(device_addr_o[0]), 128'(32'h0010_0000));
    adv();
    idle(); drsp(0, 32'hDEAD_BEEF, 1'b0); settle();
    chk("r032_rv",  128'(host_rvalid_o),   128'(2'b10));
    chk("r032_rd",  128'(host_rdata_o[1]), 128'(32'hDEAD_BEEF));
    chk("r032_err", 128'(host_err_o),      128'(2'b00));
    adv();

    // both hosts contend: grants alternate
    for (int k = 0; k < 4; k++) begin
      idle(); hreq(0, MEM_START); hreq(1, MEM_START);
      if (k > 0) drsp(0, 32'h1000 + k, 1'b0);
      settle();
      chk("r033_gnt", 128'(host_gnt_o),
          128'((k % 2 == 0) ? 2'b01 : 2'b10));
      adv();
    end
    idle(); drsp(0, 32'h2000, 1'b0); settle(); adv();

    // decode miss
    idle(); hreq(0, 32'h4000_0000); settle();
    chk("r034_gnt",  128'(host_gnt_o),   128'(2'b01));
    chk("r034_dreq", 128'(device_req_o), 128'(3'b000));
    adv();
    idle(); settle();
    chk("r034_rv",  128'(host_rvalid_o),   128'(2'b01));
    chk("r034_err", 128'(host_err_o),      128'(2'b01));
    chk("r034_rd",  128'(host_rdata_o[0]), 128'(32'h0));
    adv();

    // outstanding limit
    for (int c = 0; c < 6; c++) begin
      idle(); hreq(0, MEM_START);
      if (c == 4) drsp(0, 32'h55, 1'b0);
      settle();
      chk("r035_gnt", 128'(host_gnt_o),
          128'((c < 2 || c == 5) ? 2'b01 : 2'b00));
      if (c == 4) chk("r035_rv", 128'(host_rvalid_o), 128'(2'b01));
      adv();
    end
    for (int c = 0; c < 2; c++) begin
      idle(); drsp(0, 32'h66 + c, 1'b0); settle(); adv();
    end

    // target switch waits for drain
    idle(); hreq(0, MEM_START); settle();
    chk("r036_gnt0", 128'(host_gnt_o), 128'(2'b01));
    adv();
    for (int c = 0; c < 4; c++) begin
      idle(); hreq(0, GPIO_START);
      if (c == 2) drsp(0, 32'h77, 1'b0);
      settle();
      chk("r036_gnt", 128'(host_gnt_o),
          128'((c == 3) ? 2'b01 : 2'b00));
      chk("r036_dreq", 128'(device_req_o),
          128'((c == 3) ? 3'b010 : 3'b000));
      adv();
    end
    idle(); drsp(1, 32'hCAFE, 1'b0); settle();
    chk("r036_rv", 128'(host_rvalid_o), 128'(2'b01));
    adv();

    // overlapping windows: lowest index wins
    idle(); hreq(1, 32'h8000_1004); settle();
    chk("dec_periph", 128'(device_req_o), 128'(3'b100));
    adv();
    idle(); drsp(2, 32'h88, 1'b0); settle(); adv();
    idle(); hreq(1, 32'h8000_0FFC); settle();
    chk("dec_gpio", 128'(device_req_o), 128'(3'b010));
    adv();
    idle(); drsp(1, 32'h99, 1'b1); settle();
    chk("dec_err", 128'(host_err_o), 128'(2'b10));
    adv();

    // reset with requests in flight
    idle(); hreq(0, MEM_START); settle(); adv();
    idle(); hreq(0, MEM_START); settle(); adv();
    idle(); rst_i = 1'b1; hreq(0, MEM_START); settle();
    chk("r037_rgnt", 128'(host_gnt_o), 128'(2'b00));
    adv();
    rst_i = 1'b0;
    idle(); drsp(0, 32'hBAD, 1'b0); settle();
    chk("r037_drop", 128'(host_rvalid_o), 128'(2'b00));
    adv();
    idle(); hreq(1, MEM_START); settle();
    chk("r037_gnt", 128'(host_gnt_o), 128'(2'b10));
    adv();
    idle(); drsp(0, 32'h1234, 1'b0); settle();
    chk("r037_rv", 128'(host_rvalid_o),   128'(2'b10));
    chk("r037_rd", 128'(host_rdata_o[1]), 128'(32'h1234));
    adv();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_i = ($urandom_range(0, 149) == 0);
      for (int h = 0; h < NH; h++) begin
        logic [AW-1:0] a;
        case ($urandom_range(0, 4))
          0: a = MEM_START | ($urandom & 32'h000F_FFFC);
          1: a = GPIO_START | ($urandom & 32'h0000_0FFC);
          2: a = UART_START | ($urandom & 32'h0000_0FFC);
          3: a = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
          default: a = $urandom;
        endcase
        host_req_i[h]   = ($urandom_range(0, 2) != 0);
        host_addr_i[h]  = a;
        host_we_i[h]    = $urandom_range(0, 1);
        host_be_i[h]    = BW'($urandom);
        host_wdata_i[h] = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
        device_rvalid_i[d] = ($urandom_range(0, 2) == 0);
        device_rdata_i[d]  = $urandom;
        device_err_i[d]    = ($urandom_range(0, 7) == 0);
      end
      settle();
      adv();
    end
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
